// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/funct decode constants, redirect codes and BHT counter reset value
package ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [2:0] JOP_NONE = 3'b000;
  localparam logic [2:0] JOP_BR   = 3'b001;
  localparam logic [2:0] JOP_REG  = 3'b010;
  localparam logic [2:0] JOP_JMP  = 3'b011;
  localparam logic [2:0] JOP_SEQ  = 3'b100;
  localparam logic [1:0] CNT_INIT = 2'b01;
  function automatic logic is_branch(input logic [5:0] op);
    return op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: direct-mapped table of 2-bit saturating counters, async read, one write port
module bht_2bit
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_taken
);
  logic [1:0] r_cnt [DEPTH];
  logic [1:0] w_cur;
  assign o_rd_cnt = r_cnt[i_rd_idx];
  assign w_cur = r_cnt[i_wr_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= CNT_INIT;
    else if (i_we)
      r_cnt[i_wr_idx] <= i_taken ? w_cur + {1'b0, w_cur != 2'b11}
                                 : w_cur - {1'b0, w_cur != 2'b00};
endmodule

// File: rtl/jump_ctrl_pred.sv
// jump_ctrl_pred: IF-stage branch prediction plus EX-stage resolution, redirect/flush
// and saturating branch/mispredict statistics.
module jump_ctrl_pred
  import ctrl_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   i_if_pc,
  input  logic [5:0]        i_if_opcode,
  output logic              o_pred_taken,
  input  logic              i_ex_valid,
  input  logic              i_stall,
  input  logic [PC_W-1:0]   i_ex_pc,
  input  logic [5:0]        i_ex_opcode,
  input  logic [5:0]        i_ex_funct,
  input  logic              i_ex_zero,
  input  logic              i_ex_pred_taken,
  output logic [2:0]        o_jump_op,
  output logic              o_flush,
  output logic [STAT_W-1:0] o_branch_cnt,
  output logic [STAT_W-1:0] o_mispred_cnt
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  logic [1:0]        w_if_cnt;
  logic              w_act, w_ex_br, w_taken, w_mis, w_reg, w_jmp, w_upd, w_unused;
  logic [STAT_W-1:0] r_branch_cnt, r_mispred_cnt;
  bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_idx (i_if_pc[IDX_W+1:2]),
    .o_rd_cnt (w_if_cnt),
    .i_we     (w_upd),
    .i_wr_idx (i_ex_pc[IDX_W+1:2]),
    .i_taken  (w_taken)
  );
  assign w_unused = ^{i_if_pc[PC_W-1:IDX_W+2], i_if_pc[1:0], i_ex_pc[PC_W-1:IDX_W+2], i_ex_pc[1:0], w_if_cnt[0]};
  assign o_pred_taken = is_branch(i_if_opcode) & w_if_cnt[1];
  assign w_act   = i_ex_valid & ~i_stall;
  assign w_ex_br = is_branch(i_ex_opcode);
  assign w_taken = (i_ex_opcode == OP_BEQ) ? i_ex_zero : ~i_ex_zero;
  assign w_mis   = w_ex_br & (w_taken != i_ex_pred_taken);
  assign w_reg   = i_ex_opcode == OP_RTYPE && (i_ex_funct == FN_JR || i_ex_funct == FN_JALR);
  assign w_jmp   = i_ex_opcode == OP_J || i_ex_opcode == OP_JAL;
  assign w_upd   = w_act & w_ex_br;
  // jumps are never predicted, so they always redirect; branches only on mispredict
  always_comb
    o_jump_op = !w_act ? JOP_NONE :
                w_reg  ? JOP_REG  :
                w_jmp  ? JOP_JMP  :
                w_mis  ? (w_taken ? JOP_BR : JOP_SEQ) : JOP_NONE;
  assign o_flush = o_jump_op != JOP_NONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd) begin
      r_branch_cnt  <= r_branch_cnt + STAT_W'(r_branch_cnt != '1);
      r_mispred_cnt <= r_mispred_cnt + STAT_W'(w_mis && r_mispred_cnt != '1);
    end
  assign o_branch_cnt  = r_branch_cnt;
  assign o_mispred_cnt = r_mispred_cnt;
endmodule

// File: doc/jump_ctrl_pred.md
Name: jump_ctrl_pred

Overview:
- Pipelined successor to the single-cycle jump decoder.
- Holds a direct-mapped branch history table (BHT) of 2-bit saturating counters.
  - Predicts beq/bne taken/not-taken at IF.
  - Resolves all control transfers at EX and issues redirect + flush on jumps and mispredicts.
  - Keeps saturating branch/mispredict statistics counters.
- Sits between the IF PC-select mux and the EX stage of the 5-stage CPU.

Parameters:
- PC_W, 32, program counter width.
- BHT_DEPTH, 16, number of BHT entries; power of 2, minimum 2.
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- if_pc  in  PC_W  PC of the instruction being fetched.
- if_opcode  in  6  predecoded opcode of the fetched instruction.
- pred_taken  out  1  IF prediction for the fetched instruction.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- stall  in  1  pipeline stall; freezes EX resolution and updates.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_opcode  in  6  EX opcode.
- ex_funct  in  6  EX funct.
- ex_zero  in  1  ALU zero flag of the EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction.
- jump_op  out  3  redirect select for the PC mux.
- flush  out  1  kill IF/ID instructions this cycle.
- branch_cnt  out  STAT_W  resolved conditional branches.
- mispred_cnt  out  STAT_W  mispredicted conditional branches.

Behaviour:
- IDX_W = log2(BHT_DEPTH). BHT index = pc[IDX_W+1:2] for both lookup and update.
- Prediction (combinational, IF):
  - pred_taken = counter[idx][1] when if_opcode is 000100 (beq) or 000101 (bne); otherwise 0.
- Resolution (combinational, EX), active only when ex_valid=1 and stall=0; otherwise jump_op=000 and flush=0.
  - Instruction classes:
    - jr: opcode 000000, funct 001000.
    - jalr: opcode 000000, funct 001001.
    - j/jal: opcode 000010 / 000011.
    - beq: actual_taken = ex_zero.
    - bne: actual_taken = !ex_zero.
  - jump_op encoding:
    - 000: no redirect.
    - 001: branch target.
    - 010: register (jr/jalr).
    - 011: jump immediate (j/jal).
    - 100: fall-through, ex_pc+4.
    - 101–111: never driven.
  - jr/jalr -> 010; j/jal -> 011. These are never predicted, so flush is always asserted.
  - Branch with actual_taken=1 and ex_pred_taken=0 -> 001.
  - Branch with actual_taken=0 and ex_pred_taken=1 -> 100.
  - Branch correctly predicted -> 000.
  - All other opcodes -> 000.
  - flush = (jump_op != 000).
- Update (sequential, on clk rise when ex_valid && !stall && EX is beq/bne):
  - counter[ex_idx]: taken -> increment, saturating at 11; not taken -> decrement, saturating at 00.
  - branch_cnt += 1, saturating at all-ones.
  - mispred_cnt += 1 on mispredict, saturating at all-ones.
- Same-cycle lookup and update of the same index: pred_taken uses the pre-update value. The new value is visible the next cycle.
- stall=1 or ex_valid=0: no state change, outputs as above.
- Reset (rst=0, asynchronous):
  - Every counter = 01 (weakly not-taken); branch_cnt = 0; mispred_cnt = 0.
  - pred_taken reflects reset counters, i.e. 0.
  - jump_op/flush follow the combinational rules.
  - Reset asserted mid-update wins; no partial update is retained.
- Latency: prediction and resolution are 0-cycle combinational; state is updated 1 cycle after resolution.

Decomposition:
- Shared package ctrl_pkg:
  - Opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL.
  - Funct constants: FN_JR, FN_JALR.
  - jump_op codes: JOP_NONE, JOP_BR, JOP_REG, JOP_JMP, JOP_SEQ.
  - Counter reset value CNT_INIT = 2'b01.
- Sub-module bht_2bit:
  - Parameter DEPTH.
  - Async read port, single write port with saturating inc/dec.
  - Async active-low reset to CNT_INIT.
- Top module holds the decode, mispredict logic and statistics counters.

Test Plan:
- Reset, then lookup beq at if_pc=0x40 -> pred_taken=0; branch_cnt=0, mispred_cnt=0.
- EX beq, ex_pc=0x40, ex_zero=1, ex_pred_taken=0 -> jump_op=001, flush=1.
  - Next cycle: counter[0]=10, lookup at 0x40 gives pred_taken=1, mispred_cnt=1.
- Two further taken beq at 0x40 -> counter saturates at 11.
  - Then bne at 0x40 with ex_zero=1, ex_pred_taken=1 -> jump_op=100, flush=1, counter=10.
- EX jr (000000/001000) and j (000010) with ex_valid=1 -> jump_op=010 and 011, flush=1; BHT and stats unchanged.
  - Same with stall=1 or ex_valid=0 -> jump_op=000, flush=0, no update.
- Same-index lookup and update in one cycle (if_pc=ex_pc=0x80, counter 01, taken) -> pred_taken=0 that cycle, 1 the next.
  - With BHT_DEPTH=4, PC 0x80 and 0x90 alias and share a counter.
- Preload mispred_cnt near all-ones (STAT_W=4, 15 mispredicts), then one more -> holds 0xF.
  - Assert rst mid-run -> all counters and stats clear immediately, without waiting for clk.
